counter_mod: RTL

Parametrised up/down counter that supersedes the fixed 8-bit free-running counter. It adds configurable width, a programmable modulus, wrap or saturate mode, count enable, direction, synchronous clear, parallel load, a terminal-count pulse and a sticky overflow flag. It is a leaf timing/sequencing primitive used wherever the design needs event counting, dividers or bounded indices.

---
 rtl/counter_mod.sv | 86 ++++++++
 1 files changed

// File: rtl/counter_mod.sv
// Parametrised up/down counter with programmable modulus, wrap or saturate at the
// bounds, clear, parallel load, a terminal-count pulse and a sticky overflow flag.
module counter_mod #(
   parameter int             WIDTH     = 8,
   parameter logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}},
   parameter bit             SATURATE  = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             up,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] value,
   output logic             tc,
   output logic             ovf
);

   logic [WIDTH-1:0] r_value;
   logic             r_tc;
   logic             r_ovf;

   logic [WIDTH-1:0] w_next_value;
   logic             w_next_tc;
   logic             w_next_ovf;
   logic             w_at_max;
   logic             w_at_min;
   logic [WIDTH-1:0] w_load_clamped;

   // Bounds compare against MAX_VALUE, not the natural WIDTH-bit limit, so a
   // short modulus wraps at MAX_VALUE.
   assign w_at_max       = (r_value == MAX_VALUE);
   assign w_at_min       = (r_value == '0);
   assign w_load_clamped = (load_value > MAX_VALUE) ? MAX_VALUE : load_value;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      w_next_value = r_value;
      w_next_tc    = 1'b0;
      w_next_ovf   = r_ovf;

      if (clear) begin
         w_next_value = '0;
         w_next_ovf   = 1'b0;
      end else if (load) begin
         w_next_value = w_load_clamped;
      end else if (en) begin
         if (up) begin
            if (w_at_max) begin
               w_next_value = SATURATE ? MAX_VALUE : '0;
               w_next_tc    = 1'b1;
               w_next_ovf   = 1'b1;
            end else begin
               w_next_value = r_value + 1'b1;
            end
         end else begin
            if (w_at_min) begin
               w_next_value = SATURATE ? '0 : MAX_VALUE;
               w_next_tc    = 1'b1;
               w_next_ovf   = 1'b1;
            end else begin
               w_next_value = r_value - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
      if (!reset_n) begin
         r_value <= '0;
         r_tc    <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_value <= w_next_value;
         r_tc    <= w_next_tc;
         r_ovf   <= w_next_ovf;
      end
   end

   assign value = r_value;
   assign tc    = r_tc;
   assign ovf   = r_ovf;

endmodule
